// File: rtl/mult_add_ctrl.sv
// Repeated-addition multiplier controller: sequences an external toggle-load
// down-counter (AR) and accumulates the multiplicand once per count.
module mult_add_ctrl #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 2**WIDTH + 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic                 ar_cmpltd,
    output logic                 ar_select,
    output logic [WIDTH-1:0]     ar_in,
    output logic                 ar_clear,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int TW = $clog2(TIMEOUT + 1);

    // state   | meaning
    // S_IDLE  | waiting for start, AR held
    // S_CLEAR | AR clear pulse, product zeroed
    // S_LOAD  | toggle b_reg into the freshly cleared AR
    // S_COUNT | decrement AR and accumulate until zero-detect or timeout
    // S_DONE  | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_COUNT,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [TW-1:0]          r_tmo;
    logic [2*WIDTH-1:0]     r_product;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_error;
    logic                   r_ar_clear;
    logic                   w_timeout;
    logic                   w_decrement;

    assign w_timeout   = (r_tmo == TW'(TIMEOUT));
    // Count mode always toggles AR bit 0, so it is only enabled while actually counting.
    assign w_decrement = (r_state == S_COUNT) && !ar_cmpltd && !w_timeout;

    assign ar_select = !w_decrement;
    assign ar_in     = (r_state == S_LOAD) ? r_b : '0;
    assign ar_clear  = r_ar_clear;
    assign product   = r_product;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_tmo      <= '0;
            r_product  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_ar_clear <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a        <= a_in;
                        r_b        <= b_in;
                        r_error    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_ar_clear <= 1'b1;
                        r_state    <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_product  <= '0;
                    r_ar_clear <= 1'b0;
                    r_state    <= S_LOAD;
                end
                S_LOAD: begin
                    r_tmo   <= '0;
                    r_state <= S_COUNT;
                end
                S_COUNT: begin
                    if (ar_cmpltd) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_product <= r_product + {{WIDTH{1'b0}}, r_a};
                        r_tmo     <= r_tmo + TW'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_add_ctrl.sv
// Bench for mult_add_ctrl: models the external AR counter and checks the
// controller against a transaction-level timeline model every cycle.
module tb_mult_add_ctrl;

    localparam int W   = 4;
    localparam int TMO = 2**W + 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   a_in;
    logic [W-1:0]   b_in;
    logic           ar_cmpltd;
    logic           ar_select;
    logic [W-1:0]   ar_in;
    logic           ar_clear;
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;
    logic           error;

    always #5 clk = ~clk;

    mult_add_ctrl #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .ar_cmpltd (ar_cmpltd),
        .ar_select (ar_select),
        .ar_in     (ar_in),
        .ar_clear  (ar_clear),
        .product   (product),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    // AR register: toggle load when selected, count down otherwise
    logic [W-1:0] ar_q;
    logic         force_zero;
    always @(posedge clk) begin
        if (reset || ar_clear) ar_q <= '0;
        else if (ar_select)    ar_q <= ar_q ^ ar_in;
        else                   ar_q <= ar_q - 1'b1;
    end
    assign ar_cmpltd = force_zero ? 1'b0 : (ar_q == '0);

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Timeline model: t counts cycles since the accepted start (t=1 is the first).
    bit m_active;
    int m_t, m_n, m_a, m_b;
    bit m_forced, m_err, m_prod_known, m_ar_known;
    int m_prod_hold;
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_active     = 1'b0;
            m_err        = 1'b0;
            m_prod_hold  = 0;
            m_prod_known = 1'b1;
            m_ar_known   = 1'b1;
        end else if (m_active) begin
            if (m_t == m_n + 4) begin
                m_active = 1'b0;
                if (m_forced) begin
                    m_prod_known = 1'b0;
                    m_ar_known   = 1'b0;
                end else begin
                    m_prod_hold  = m_a * m_b;
                    m_prod_known = 1'b1;
                end
            end else begin
                m_t++;
                if (m_t == m_n + 4 && m_forced) m_err = 1'b1;
            end
        end else if (start) begin
            m_active   = 1'b1;
            m_t        = 1;
            m_a        = int'(a_in);
            m_b        = int'(b_in);
            m_forced   = force_zero;
            m_n        = force_zero ? TMO : int'(b_in);
            m_err      = 1'b0;
            m_ar_known = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int k;
            check("busy",      int'(busy),      int'(m_active && m_t <= m_n + 3));
            check("done",      int'(done),      int'(m_active && m_t == m_n + 4));
            check("ar_clear",  int'(ar_clear),  int'(m_active && m_t == 1));
            check("ar_select", int'(ar_select), int'(!(m_active && m_t >= 3 && m_t <= m_n + 2)));
            check("ar_in",     int'(ar_in),     (m_active && m_t == 2) ? m_b : 0);
            check("error",     int'(error),     int'(m_err));
            if (m_active) begin
                if (m_t == 1) begin
                    if (m_prod_known) check("product_hold", int'(product), m_prod_hold);
                end else if (!m_forced) begin
                    k = m_t - 3;
                    if (k < 0)   k = 0;
                    if (k > m_n) k = m_n;
                    check("product_acc", int'(product), m_a * k);
                end
            end else begin
                if (m_prod_known) check("product_idle", int'(product), m_prod_hold);
                if (m_ar_known)   check("ar_idle", int'(ar_q), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input int a, input int b);
        a_in  = W'(a);
        b_in  = W'(b);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called in cycle 1 after an accepted start; returns the cycle done is seen in.
    task automatic wait_done(input int bound, output int lat, output int sel_low, output int busy_n);
        lat = 1; sel_low = 0; busy_n = 0;
        while (!done && lat < bound) begin
            if (!ar_select) sel_low++;
            if (busy) busy_n++;
            tick();
            lat++;
        end
        check("done_seen", int'(done), 1);
    endtask

    int lat, sel_low, busy_n, done_cnt;

    initial begin
        reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0; force_zero = 1'b0;
        tick();
        chk_en = 1'b1;
        check("rst_product", int'(product), 0);
        check("rst_select",  int'(ar_select), 1);
        tick();
        reset = 1'b0;
        tick();

        // 5 x 3
        start_op(5, 3);
        wait_done(40, lat, sel_low, busy_n);
        check("5x3_latency", lat, 7);
        check("5x3_busy_cycles", busy_n, 6);
        check("5x3_select_low", sel_low, 3);
        check("5x3_product", int'(product), 15);
        tick(); tick();

        // 9 x 0
        start_op(9, 0);
        wait_done(40, lat, sel_low, busy_n);
        check("9x0_latency", lat, 4);
        check("9x0_select_low", sel_low, 0);
        check("9x0_product", int'(product), 0);
        check("9x0_error", int'(error), 0);
        tick();

        // 15 x 15, then AR must stay at zero while idle
        start_op(15, 15);
        wait_done(60, lat, sel_low, busy_n);
        check("15x15_latency", lat, 19);
        check("15x15_product", int'(product), 225);
        for (int i = 0; i < 10; i++) tick();
        check("15x15_ar_after", int'(ar_q), 0);

        // 7 x 2 with an ignored start during COUNT
        start_op(7, 2);
        tick(); tick();
        a_in = 4'd1; b_in = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(40, lat, sel_low, busy_n);
        check("7x2_product", int'(product), 14);
        tick(); tick();
        check("7x2_no_restart", int'(busy), 0);

        // 3 x 4: product cleared during CLEAR
        start_op(3, 4);
        tick();
        check("3x4_cleared", int'(product), 0);
        wait_done(40, lat, sel_low, busy_n);
        check("3x4_product", int'(product), 12);
        tick();

        // 6 x 10 with reset in the 4th COUNT cycle
        start_op(6, 10);
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_product", int'(product), 0);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) done_cnt++;
            tick();
        end
        check("rst_mid_no_done", done_cnt, 0);

        // Timeout with zero-detect stuck low
        force_zero = 1'b1;
        start_op(1, 5);
        wait_done(60, lat, sel_low, busy_n);
        check("tmo_latency", lat, TMO + 4);
        check("tmo_error", int'(error), 1);
        tick();
        force_zero = 1'b0;
        tick();
        check("tmo_error_sticky", int'(error), 1);
        start_op(2, 3);
        check("tmo_error_cleared", int'(error), 0);
        wait_done(40, lat, sel_low, busy_n);
        check("after_tmo_latency", lat, 7);
        check("after_tmo_product", int'(product), 6);
        tick();

        // Random traffic, extra starts and occasional resets
        for (int op = 0; op < 40; op++) begin
            int len;
            len = $urandom_range(30, 0);
            for (int c = 0; c < len; c++) begin
                a_in  = W'($urandom);
                b_in  = W'($urandom);
                start = ($urandom_range(3, 0) == 0);
                reset = ($urandom_range(40, 0) == 0);
                tick();
            end
            start = 1'b0;
            reset = 1'b0;
            for (int c = 0; c < 22; c++) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
